// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings and the arbitration rule for the memory port arbiter
package mem_port_arbiter_pkg;
   localparam logic ST_IDLE     = 1'b0;
   localparam logic ST_ACCESS   = 1'b1;
   localparam logic G_IF        = 1'b0;
   localparam logic G_DM        = 1'b1;
   localparam int   MEM_LAT_MAX = 15;
   localparam int   CNT_W       = 4;
   function automatic logic pick_winner(input logic if_elig, input logic dm_elig, input logic last_grant);
      return (if_elig && dm_elig) ? ~last_grant : (dm_elig ? G_DM : G_IF);
   endfunction
endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// mem_port_arbiter_wait_counter: loadable down counter timing one memory access
module mem_port_arbiter_wait_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);
   logic [W-1:0] cnt;
   // load wins over decrement; the count saturates at zero instead of wrapping
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (dec && cnt != '0) cnt <= cnt - 1'b1;
   assign zero = (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between the fetch and data ports
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              if_stall,
   input  logic              dm_read,
   input  logic              dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   output logic              dm_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);
   logic state;
   logic last_grant;
   logic we_lat;
   logic if_elig;
   logic dm_elig;
   logic start;
   logic done;
   logic winner;
   logic if_match;
   logic cnt_zero;
   assign if_elig  = if_req & ~if_valid;
   assign dm_elig  = (dm_read | dm_write) & ~dm_valid;
   assign start    = (state == ST_IDLE) & (if_elig | dm_elig);
   assign winner   = pick_winner(if_elig, dm_elig, last_grant);
   assign done     = (state == ST_ACCESS) & cnt_zero;
   assign if_match = if_req & (if_addr == mem_addr);
   assign mem_en   = (state == ST_ACCESS);
   assign mem_we   = mem_en & we_lat;
   assign if_stall = if_req & ~if_valid;
   assign dm_stall = (dm_read | dm_write) & ~dm_valid;
   mem_port_arbiter_wait_counter #(.W(CNT_W)) u_wait (
      .clk      (clk),
      .reset    (reset),
      .load     (start),
      .load_val (LOAD_VAL),
      .dec      (mem_en),
      .zero     (cnt_zero)
   );
   // IDLE latches the winning request and opens an access; ACCESS ends when the counter expires
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state      <= ST_IDLE;
         last_grant <= G_IF;
         we_lat     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else if (start) begin
         state      <= ST_ACCESS;
         last_grant <= winner;
         we_lat     <= (winner == G_DM) & dm_write;
         mem_addr   <= (winner == G_DM) ? dm_addr : if_addr;
         if (winner == G_DM) mem_wdata <= dm_wdata;
      end else if (done) begin
         state <= ST_IDLE;
      end
   // completion hands read data to its port; a fetch whose PC moved away is silently dropped
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         if_rdata <= '0;
         dm_rdata <= '0;
         if_valid <= 1'b0;
         dm_valid <= 1'b0;
      end else begin
         if_valid <= done & (last_grant == G_IF) & if_match;
         dm_valid <= done & (last_grant == G_DM);
         if (done && last_grant == G_IF && if_match) if_rdata <= mem_rdata;
         if (done && last_grant == G_DM && !we_lat) dm_rdata <= mem_rdata;
      end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the shared memory port arbiter
module tb_mem_port_arbiter;
   localparam int LAT = 2;
   localparam logic [31:0] MASK = 32'hA5A5_0000;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic if_req = 1'b0, dm_read = 1'b0, dm_write = 1'b0;
   logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
   logic if_valid, if_stall, dm_valid, dm_stall, mem_en, mem_we;
   logic [31:0] store_d [64];
   logic [63:0] store_v = '0;
   logic [31:0] sh_d [64];
   logic [63:0] sh_v = '0;
   int total = 0;
   int bad = 0;
   int it, dt;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // memory model: unwritten words read back as addr ^ MASK
   assign mem_rdata = store_v[mem_addr[7:2]] ? store_d[mem_addr[7:2]] : (mem_addr ^ MASK);
   always @(posedge clk)
      if (mem_en && mem_we) begin
         store_d[mem_addr[7:2]] <= mem_wdata;
         store_v[mem_addr[7:2]] <= 1'b1;
      end

   function automatic logic [31:0] exp_load(input logic [31:0] a);
      return sh_v[a[7:2]] ? sh_d[a[7:2]] : (a ^ MASK);
   endfunction

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic run_pair(input logic do_if, input logic [31:0] ia, input logic do_dm, input logic [31:0] da,
                           output int ti, output int td);
      ti = -1;
      td = -1;
      cyc;
      if_req = do_if; if_addr = ia; dm_read = do_dm; dm_addr = da;
      for (int c = 1; c <= 12; c++) begin
         cyc;
         #1;
         if (if_valid && ti < 0) begin ti = c; if_req = 1'b0; end
         if (dm_valid && td < 0) begin td = c; dm_read = 1'b0; end
      end
   endtask

   task automatic test_reset;
      if_req = 1'b1; if_addr = 32'h10; dm_read = 1'b1; dm_addr = 32'h0C;
      for (int c = 0; c < 3; c++) begin
         cyc;
         #1;
         total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%b want=0", mem_en); end
         total++; if ({if_valid, dm_valid} !== 2'b00) begin bad++; $display("FAIL rst_valids got=%b want=00", {if_valid, dm_valid}); end
         total++; if ({if_rdata, dm_rdata} !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", {if_rdata, dm_rdata}); end
      end
      cyc;
      reset = 1'b1; if_req = 1'b0;
      #1;
      total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rel_mem_en0 got=%b want=0", mem_en); end
      cyc;
      #1;
      total++; if (mem_en !== 1'b1 || mem_addr !== 32'h0C) begin bad++; $display("FAIL rel_start got=%b/%h want=1/0000000c", mem_en, mem_addr); end
      cyc;
      cyc;
      #1;
      total++; if (dm_valid !== 1'b1 || dm_rdata !== (32'h0C ^ MASK)) begin bad++; $display("FAIL rel_load got=%b/%h want=1/%h", dm_valid, dm_rdata, 32'h0C ^ MASK); end
      dm_read = 1'b0;
      cyc;
   endtask

   task automatic test_if_fetch;
      cyc;
      if_req = 1'b1; if_addr = 32'h10;
      #1;
      total++; if (if_stall !== 1'b1 || mem_en !== 1'b0) begin bad++; $display("FAIL fetch_t0 got stall=%b en=%b want 1/0", if_stall, mem_en); end
      for (int c = 1; c <= LAT; c++) begin
         cyc;
         #1;
         total++; if ({mem_en, mem_we, if_stall} !== 3'b101 || mem_addr !== 32'h10) begin bad++; $display("FAIL fetch_acc%0d got en/we/stall=%b addr=%h want 101/00000010", c, {mem_en, mem_we, if_stall}, mem_addr); end
      end
      cyc;
      #1;
      total++; if (if_valid !== 1'b1 || if_stall !== 1'b0 || if_rdata !== 32'hA5A5_0010) begin bad++; $display("FAIL fetch_done got v=%b s=%b d=%h want 1/0/a5a50010", if_valid, if_stall, if_rdata); end
      if_req = 1'b0;
      cyc;
      #1;
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL fetch_pulse got=%b want=0", if_valid); end
   endtask

   task automatic test_arbitration;
      reset = 1'b0;
      cyc;
      reset = 1'b1;
      run_pair(1'b1, 32'h10, 1'b1, 32'h0C, it, dt);
      total++; if (dt !== LAT + 1 || it !== 2 * LAT + 2) begin bad++; $display("FAIL arb_first got dm=%0d if=%0d want %0d/%0d", dt, it, LAT + 1, 2 * LAT + 2); end
      total++; if (dm_rdata !== (32'h0C ^ MASK) || if_rdata !== (32'h10 ^ MASK)) begin bad++; $display("FAIL arb_data got %h/%h", dm_rdata, if_rdata); end
      run_pair(1'b0, 32'h0, 1'b1, 32'h14, it, dt);
      total++; if (dt !== LAT + 1) begin bad++; $display("FAIL arb_dm_only got=%0d want=%0d", dt, LAT + 1); end
      run_pair(1'b1, 32'h18, 1'b1, 32'h1C, it, dt);
      total++; if (it !== LAT + 1 || dt !== 2 * LAT + 2) begin bad++; $display("FAIL arb_alt got if=%0d dm=%0d want %0d/%0d", it, dt, LAT + 1, 2 * LAT + 2); end
   endtask

   task automatic test_store_load;
      logic [31:0] prev;
      prev = 32'h1C ^ MASK;
      cyc;
      dm_write = 1'b1; dm_addr = 32'h0C; dm_wdata = 32'd99;
      for (int c = 1; c <= LAT; c++) begin
         cyc;
         #1;
         total++; if ({mem_en, mem_we} !== 2'b11 || mem_wdata !== 32'd99 || mem_addr !== 32'h0C) begin bad++; $display("FAIL store_acc%0d got en/we=%b d=%h a=%h", c, {mem_en, mem_we}, mem_wdata, mem_addr); end
      end
      cyc;
      #1;
      total++; if (dm_valid !== 1'b1 || dm_rdata !== prev) begin bad++; $display("FAIL store_done got v=%b d=%h want 1/%h", dm_valid, dm_rdata, prev); end
      sh_d[3] = 32'd99; sh_v[3] = 1'b1;
      dm_write = 1'b0;
      run_pair(1'b0, 32'h0, 1'b1, 32'h0C, it, dt);
      total++; if (dt !== LAT + 1 || dm_rdata !== exp_load(32'h0C)) begin bad++; $display("FAIL store_reload got t=%0d d=%h want %0d/%h", dt, dm_rdata, LAT + 1, exp_load(32'h0C)); end
   endtask

   task automatic test_if_abort;
      cyc;
      if_req = 1'b1; if_addr = 32'h20;
      cyc;
      cyc;
      #1;
      total++; if (mem_addr !== 32'h20 || mem_en !== 1'b1) begin bad++; $display("FAIL abort_acc got en=%b a=%h want 1/00000020", mem_en, mem_addr); end
      if_addr = 32'h40;
      cyc;
      #1;
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL abort_drop got=%b want=0", if_valid); end
      cyc;
      #1;
      total++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin bad++; $display("FAIL abort_retry got en=%b a=%h want 1/00000040", mem_en, mem_addr); end
      cyc;
      cyc;
      #1;
      total++; if (if_valid !== 1'b1 || if_rdata !== 32'hA5A5_0040) begin bad++; $display("FAIL abort_done got v=%b d=%h want 1/a5a50040", if_valid, if_rdata); end
      if_req = 1'b0;
      cyc;
   endtask

   task automatic test_reset_mid;
      int t;
      cyc;
      dm_read = 1'b1; dm_addr = 32'h30;
      cyc;
      #1;
      total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL mid_acc got=%b want=1", mem_en); end
      reset = 1'b0;
      #1;
      total++; if (mem_en !== 1'b0 || dm_rdata !== 32'h0) begin bad++; $display("FAIL mid_async got en=%b d=%h want 0/0", mem_en, dm_rdata); end
      cyc;
      cyc;
      reset = 1'b1;
      t = -1;
      for (int c = 1; c <= 8; c++) begin
         cyc;
         #1;
         if (dm_valid && t < 0) begin t = c; dm_read = 1'b0; end
      end
      total++; if (t !== LAT + 1 || dm_rdata !== (32'h30 ^ MASK)) begin bad++; $display("FAIL mid_resume got t=%0d d=%h want %0d/%h", t, dm_rdata, LAT + 1, 32'h30 ^ MASK); end
   endtask

   task automatic test_random;
      int if_age = 0, dm_age = 0, run = 0, r;
      logic [31:0] exp_dm;
      exp_dm = 32'h30 ^ MASK;
      for (int c = 0; c < 400; c++) begin
         cyc;
         #1;
         total++; if (if_stall !== (if_req & ~if_valid) || dm_stall !== ((dm_read | dm_write) & ~dm_valid)) begin bad++; $display("FAIL rnd_stall c=%0d got %b%b", c, if_stall, dm_stall); end
         if (if_valid) begin
            total++; if (!if_req || if_rdata !== (if_addr ^ MASK)) begin bad++; $display("FAIL rnd_if c=%0d got %h want %h", c, if_rdata, if_addr ^ MASK); end
         end
         if (dm_valid) begin
            if (dm_write) begin sh_d[dm_addr[7:2]] = dm_wdata; sh_v[dm_addr[7:2]] = 1'b1; end
            else exp_dm = exp_load(dm_addr);
            total++; if (!(dm_read | dm_write) || dm_rdata !== exp_dm) begin bad++; $display("FAIL rnd_dm c=%0d got %h want %h", c, dm_rdata, exp_dm); end
         end
         if (mem_we) begin
            total++; if (!dm_write || mem_addr !== dm_addr || mem_wdata !== dm_wdata) begin bad++; $display("FAIL rnd_we c=%0d a=%h d=%h", c, mem_addr, mem_wdata); end
         end
         if (mem_en) run++;
         else if (run != 0) begin
            total++; if (run != LAT) begin bad++; $display("FAIL rnd_burst c=%0d got=%0d want=%0d", c, run, LAT); end
            run = 0;
         end
         if (if_req && !if_valid) if_age++;
         if ((dm_read | dm_write) && !dm_valid) dm_age++;
         if (if_age > 2 * LAT + 3) begin total++; bad++; $display("FAIL rnd_if_timeout c=%0d got=%0d want<=%0d", c, if_age, 2 * LAT + 3); if_req = 1'b0; if_age = 0; end
         if (dm_age > 2 * LAT + 3) begin total++; bad++; $display("FAIL rnd_dm_timeout c=%0d got=%0d want<=%0d", c, dm_age, 2 * LAT + 3); dm_read = 1'b0; dm_write = 1'b0; dm_age = 0; end
         if (if_valid || !if_req) begin
            if_req = ($urandom % 3) != 0; if_addr = {24'h0, 1'b1, 5'($urandom), 2'b00}; if_age = 0;
         end else if ($urandom % 16 == 0) begin
            if_addr = {24'h0, 1'b1, 5'($urandom), 2'b00}; if_age = 0;
         end
         if (dm_valid || !(dm_read | dm_write)) begin
            r = int'($urandom % 4);
            dm_read = (r == 1) || (r == 3); dm_write = (r >= 2);
            dm_addr = {26'h0, 4'($urandom), 2'b00}; dm_wdata = $urandom; dm_age = 0;
         end
      end
      if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
      repeat (2 * LAT + 4) cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_if_fetch;
      test_arbitration;
      test_store_load;
      test_if_abort;
      test_reset_mid;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
